// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
//   state_e     : FSM state encoding driven onto stopwatch_ctrl.state
//   STATE_W     : width of the state encoding
//   SYNC_STAGES : depth of the button synchronisers
package stopwatch_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press-pulse generator for one raw push button.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous raw button input
//   level   : debounced level, normalised so pressed = 1
//   press   : one-cycle pulse on the debounced 0 -> 1 transition
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // One extra bit so the counter cannot wrap before the threshold.
  localparam int unsigned      CNT_W        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed_sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;

  // XOR with the released raw value maps pressed to 1 for either polarity.
  assign pressed_sync = sync_q[SYNC_STAGES-1] ^ RELEASED_RAW;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (pressed_sync != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = pressed_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RELEASED_RAW}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle control for the two-digit seconds display counter.
// Debounces the raw start and clear buttons and drives the counter's run
// enable and one-cycle clear.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   btn_start : raw run/pause button (asynchronous)
//   btn_clear : raw clear button (asynchronous)
//   start     : registered run enable, high only in RUN
//   clr       : registered one-cycle clear pulse
//   state     : current FSM state (IDLE=0, RUN=1, PAUSE=2)
// Build option: define STOPWATCH_LONG_PRESS_CLEAR_EN to make holding the start
// button for LONG_PRESS_CYCLES also clear the stopwatch.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_clear,
  output logic               start,
  output logic               clr,
  output logic [STATE_W-1:0] state
);

  logic   start_level, start_press;
  logic   clear_level_unused, clear_press;
  logic   clear_evt;
  state_e state_q, state_d;
  logic   start_q, start_d;
  logic   clr_q, clr_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_start_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_start),
    .level  (start_level),
    .press  (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_clear_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_clear),
    .level  (clear_level_unused),
    .press  (clear_press)
  );

`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
  localparam int unsigned       HOLD_W   = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_clear;

  // Saturating at HOLD_MAX means the clear fires only on the way in,
  // i.e. once per hold.
  always_comb begin
    hold_d     = '0;
    long_clear = 1'b0;
    if (start_level) begin
      if (hold_q == HOLD_MAX) begin
        hold_d = hold_q;
      end else begin
        hold_d     = hold_q + 1'b1;
        long_clear = (hold_d == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign clear_evt = clear_press | long_clear;
`else
  localparam int unsigned long_press_unused = LONG_PRESS_CYCLES;
  logic start_level_unused;

  assign start_level_unused = start_level;
  assign clear_evt          = clear_press;
`endif

  // Clear takes priority over any start press in the same cycle.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (clear_evt) begin
      state_d = StIdle;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle:  if (start_press) state_d = StRun;
        StRun:   if (start_press) state_d = StPause;
        StPause: if (start_press) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
    start_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      clr_q   <= clr_d;
    end
  end

  assign state = state_q;
  assign start = start_q;
  assign clr   = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4,
// BTN_ACTIVE_LOW=1 and LONG_PRESS_CYCLES=16. Buttons are 1 when released.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_clear;
  logic       start;
  logic       clr;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .BTN_ACTIVE_LOW   (1'b1),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .start    (start),
    .clr      (clr),
    .state    (state)
  );

  // One step: hold the buttons for 'cycles' clocks, then expect the final
  // state/start, the number of clr pulses seen, and optionally no RUN visit.
  typedef struct {
    string      name;
    logic       bs;
    logic       bc;
    int         cycles;
    logic [1:0] st;
    logic       run;
    int         clrs;
    bit         no_run;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   clr_seen;
  bit   run_seen;
  logic prev_clr = 1'b0;

  function automatic vec_t mk(string nm, logic bs, logic bc, int cyc, logic [1:0] st,
                              logic run, int clrs, bit nr);
    vec_t v;
    v.name = nm; v.bs = bs; v.bc = bc; v.cycles = cyc;
    v.st = st; v.run = run; v.clrs = clrs; v.no_run = nr;
    return v;
  endfunction

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample();
    if (clr) begin
      clr_seen++;
      check("clr single-cycle", int'(prev_clr), 0);
    end
    prev_clr = clr;
    if (state == 2'd1) run_seen = 1'b1;
  endtask

  task automatic run_step(vec_t v);
    vec_t e;
    btn_start = v.bs;
    btn_clear = v.bc;
    sb.push_back(v);
    clr_seen = 0;
    run_seen = 1'b0;
    repeat (v.cycles) begin
      @(negedge clk);
      sample();
    end
    e = sb.pop_front();
    check({e.name, " state"}, int'(state), int'(e.st));
    check({e.name, " start"}, int'(start), int'(e.run));
    check({e.name, " clr pulses"}, clr_seen, e.clrs);
    if (e.no_run) check({e.name, " entered RUN"}, int'(run_seen), 0);
  endtask

  initial begin
    btn_start = 1'b1;
    btn_clear = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset state", int'(state), 0);
    check("reset start", int'(start), 0);
    check("reset clr", int'(clr), 0);
    rst = 1'b0;

    vecs.push_back(mk("idle hold",      1, 1, 20, 2'd0, 0, 0, 1));
    vecs.push_back(mk("glitch",         0, 1,  3, 2'd0, 0, 0, 1));
    vecs.push_back(mk("after glitch",   1, 1, 10, 2'd0, 0, 0, 1));
    vecs.push_back(mk("press run",      0, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("release run",    1, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("press pause",    0, 1, 10, 2'd2, 0, 0, 0));
    vecs.push_back(mk("release pause",  1, 1, 10, 2'd2, 0, 0, 0));
    vecs.push_back(mk("press resume",   0, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("release resume", 1, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("clear in run",   1, 0, 10, 2'd0, 0, 1, 0));
    vecs.push_back(mk("clear release",  1, 1, 10, 2'd0, 0, 0, 1));
    vecs.push_back(mk("press run 2",    0, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("release run 2",  1, 1, 10, 2'd1, 1, 0, 0));
    vecs.push_back(mk("press pause 2",  0, 1, 10, 2'd2, 0, 0, 0));
    vecs.push_back(mk("release pause2", 1, 1, 10, 2'd2, 0, 0, 0));
    vecs.push_back(mk("simultaneous",   0, 0, 10, 2'd0, 0, 1, 1));
    vecs.push_back(mk("simul release",  1, 1, 10, 2'd0, 0, 0, 1));
    vecs.push_back(mk("clear in idle",  1, 0, 10, 2'd0, 0, 1, 1));
    vecs.push_back(mk("idle release",   1, 1, 10, 2'd0, 0, 0, 1));
    vecs.push_back(mk("held start",     0, 1, 14, 2'd1, 1, 0, 0));
    vecs.push_back(mk("held release",   1, 1, 10, 2'd1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run_step(vecs[i]);

    // Reset while running drops straight back to idle.
    rst = 1'b1;
    @(negedge clk);
    check("mid-run reset state", int'(state), 0);
    check("mid-run reset start", int'(start), 0);
    check("mid-run reset clr", int'(clr), 0);
    rst = 1'b0;

    // Reset partway through a debounce discards the pending press: without
    // the reset this 5-cycle press would have been accepted.
    btn_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    btn_start = 1'b1;
    run_seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sample();
    end
    check("mid-debounce reset state", int'(state), 0);
    check("mid-debounce reset RUN visit", int'(run_seen), 0);

`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
    run_step(mk("lp press run",   0, 1, 10, 2'd1, 1, 0, 0));
    run_step(mk("lp release run", 1, 1, 10, 2'd1, 1, 0, 0));
    run_step(mk("lp to pause",    0, 1, 10, 2'd2, 0, 0, 0));
    run_step(mk("lp pause rel",   1, 1, 10, 2'd2, 0, 0, 0));
    run_step(mk("long press",     0, 1, 40, 2'd0, 0, 1, 0));
    check("long press visited RUN", int'(run_seen), 1);
    run_step(mk("long release",   1, 1, 10, 2'd0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
